// File: rtl/ntt_scheduler_if.sv
// ntt_scheduler_if -- control/status bundle between an NTT controller and the
// NTT scheduler.
//   i_start    : transform request, sampled only while the scheduler is idle
//   i_intt     : mode captured together with i_start (1 = inverse transform)
//   i_stall    : memory read port busy, holds back the next read beat
//   o_busy     : scheduler is not idle
//   o_done     : one-cycle completion pulse
//   o_rd_en    : read strobe, o_rd_addr = beat index
//   o_wr_en    : write strobe, o_wr_addr = beat index
//   o_layer    : logical butterfly layer of the current read beat
//   o_intt     : mode of the current read beat (permutation network control)
//   o_permute  : enable output permutation on the current read beat
// Modports: slave = scheduler side, master = requester side.
interface ntt_scheduler_if #(
    parameter int NUM_LAYERS = 8,
    parameter int BEATS      = 4
);
    localparam int AW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic          i_start;
    logic          i_intt;
    logic          i_stall;
    logic          o_busy;
    logic          o_done;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [LW-1:0] o_layer;
    logic          o_intt;
    logic          o_permute;

    modport slave (
        input  i_start, i_intt, i_stall,
        output o_busy, o_done, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
               o_layer, o_intt, o_permute
    );

    modport master (
        output i_start, i_intt, i_stall,
        input  o_busy, o_done, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
               o_layer, o_intt, o_permute
    );
endinterface

// File: rtl/ntt_scheduler.sv
// ntt_scheduler -- sequences the read/write beats of a multi-layer NTT/INTT.
// For every layer the BEATS read beats are issued (held back by i_stall), each
// read produces a write of the same beat exactly BFU_LAT cycles later, and the
// next layer starts only after the last write of the current one has left.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : ntt_scheduler_if.slave (start/mode/stall in, strobes/status out)
// All outputs are registered. i_stall is sampled at the clock edge, so a stall
// seen at the edge closing cycle k suppresses the read presented in cycle k+1.
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | issuing read beats of the current layer
// DRAIN | all beats issued, waiting for outstanding writes to leave
// DONE  | completion pulse on o_done
module ntt_scheduler #(
    parameter int NUM_LAYERS = 8,
    parameter int BEATS      = 4,
    parameter int BFU_LAT    = 3
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ntt_scheduler_if.slave bus
);
    localparam int AW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    // Every pipeline stage except the output stage still holds a future write.
    localparam logic [BFU_LAT-1:0] PEND_MASK = {BFU_LAT{1'b1}} >> 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] beat_q, beat_d;
    logic [LW-1:0] layer_q, layer_d;
    logic          mode_q, mode_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [LW-1:0] layer_out_q, layer_out_d;
    logic          intt_q, intt_d;
    logic          permute_q, permute_d;

    logic [BFU_LAT-1:0] pipe_v;
    logic [AW-1:0]      pipe_a [BFU_LAT];

    logic          pending;
    logic          try_issue;
    logic [AW-1:0] rd_beat;

    // A read presented this cycle has not entered the pipeline yet.
    assign pending = rd_en_q | (|(pipe_v & PEND_MASK));

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        layer_d     = layer_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        try_issue   = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        layer_out_d = '0;
        intt_d      = 1'b0;
        permute_d   = 1'b0;
        rd_beat     = '0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    mode_d    = bus.i_intt;
                    beat_d    = '0;
                    layer_d   = '0;
                    state_d   = READ;
                    try_issue = 1'b1;
                end
            end
            READ: begin
                try_issue = 1'b1;
            end
            DRAIN: begin
                if (!pending) begin
                    beat_d = '0;
                    if (layer_q == LAST_LAYER) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        layer_d   = layer_q + LW'(1);
                        state_d   = READ;
                        try_issue = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Issue decision uses the counters as they will be after this edge,
        // so the first beat of a layer goes out on the same edge that enters READ.
        if (try_issue && !bus.i_stall) begin
            rd_beat     = beat_d;
            rd_en_d     = 1'b1;
            rd_addr_d   = rd_beat;
            layer_out_d = mode_d ? (LAST_LAYER - layer_d) : layer_d;
            intt_d      = mode_d;
            permute_d   = !mode_d && (layer_d == LAST_LAYER);
            if (rd_beat == LAST_BEAT) begin
                beat_d  = '0;
                state_d = DRAIN;
            end else begin
                beat_d = rd_beat + AW'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            layer_q     <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            layer_out_q <= '0;
            intt_q      <= 1'b0;
            permute_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            layer_q     <= layer_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            layer_out_q <= layer_out_d;
            intt_q      <= intt_d;
            permute_q   <= permute_d;
        end
    end

    // Write pipeline: free-running shift register fed by the presented read,
    // so stage i holds the read from i+1 cycles ago; the last stage is the write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < BFU_LAT; i++) begin
                pipe_a[i] <= '0;
            end
        end else begin
            for (int i = BFU_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            pipe_v[0] <= rd_en_q;
            pipe_a[0] <= rd_en_q ? rd_addr_q : '0;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_wr_en   = pipe_v[BFU_LAT-1];
    assign bus.o_wr_addr = pipe_a[BFU_LAT-1];
    assign bus.o_layer   = layer_out_q;
    assign bus.o_intt    = intt_q;
    assign bus.o_permute = permute_q;

endmodule

// File: tb/tb_ntt_scheduler.sv
// tb_ntt_scheduler -- self-checking bench for ntt_scheduler.
// A schedule model derives, from the stall pattern, the cycle of every read,
// write and the done pulse; every output is compared against it each cycle.
// Cycle numbering is relative to the cycle in which i_start is presented
// (cycle 0). A stall present during cycle k blocks the read of cycle k+1.
module tb_ntt_scheduler;
    localparam int NL   = 8;
    localparam int NB   = 4;
    localparam int LAT  = 3;
    localparam int MAXC = 512;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    ntt_scheduler_if #(.NUM_LAYERS(NL), .BEATS(NB)) bus ();

    ntt_scheduler #(.NUM_LAYERS(NL), .BEATS(NB), .BFU_LAT(LAT)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit stl      [MAXC];
    bit exp_rd   [MAXC];
    int exp_addr [MAXC];
    int exp_lay  [MAXC];
    bit exp_perm [MAXC];
    bit exp_wr   [MAXC];
    int exp_wadr [MAXC];
    int exp_done;

    int rd_cyc[$];
    int wr_cyc[$];
    int obs_done;
    int perm_first;

    task automatic check(input string tag, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, expv, $time);
        end
    endtask

    function automatic int outs_packed();
        return int'({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rd_addr, bus.o_wr_en,
                     bus.o_wr_addr, bus.o_layer, bus.o_intt, bus.o_permute});
    endfunction

    task automatic clear_stall();
        for (int i = 0; i < MAXC; i++) stl[i] = 1'b0;
    endtask

    task automatic rand_stall(input int one_in);
        for (int i = 0; i < MAXC; i++) stl[i] = ($urandom_range(one_in - 1) == 0);
    endtask

    // Schedule: layers in order, beats in order; a read lands in the first
    // cycle t at or after its earliest slot whose preceding cycle is stall-free.
    // Its write is LAT cycles later; a new layer may start the cycle after the
    // previous layer's last write; done follows the final write by one cycle.
    task automatic build_model(input bit mode);
        int t;
        int last_w;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0; exp_addr[i] = 0; exp_lay[i] = 0; exp_perm[i] = 0;
            exp_wr[i] = 0; exp_wadr[i] = 0;
        end
        t = 1;
        last_w = 0;
        for (int l = 0; l < NL; l++) begin
            for (int b = 0; b < NB; b++) begin
                while (stl[t-1] && t < MAXC - LAT - 4) t++;
                exp_rd[t]   = 1;
                exp_addr[t] = b;
                exp_lay[t]  = mode ? (NL - 1 - l) : l;
                exp_perm[t] = !mode && (l == NL - 1);
                exp_wr[t+LAT]   = 1;
                exp_wadr[t+LAT] = b;
                last_w = t + LAT;
                t++;
            end
            t = last_w + 1;
        end
        exp_done = last_w + 1;
    endtask

    task automatic run_xform(input bit mode, input bit hold_start, input int busy_pulse);
        int d;
        build_model(mode);
        d = exp_done;
        rd_cyc.delete();
        wr_cyc.delete();
        obs_done   = -1;
        perm_first = -1;
        bus.i_start = 1'b1;
        bus.i_intt  = mode;
        bus.i_stall = stl[0];
        for (int k = 1; k <= d + 1; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("busy",    int'(bus.o_busy),    int'(k <= d));
            check("done",    int'(bus.o_done),    int'(k == d));
            check("rd_en",   int'(bus.o_rd_en),   int'(exp_rd[k]));
            check("wr_en",   int'(bus.o_wr_en),   int'(exp_wr[k]));
            if (exp_rd[k]) begin
                check("rd_addr", int'(bus.o_rd_addr), exp_addr[k]);
                check("layer",   int'(bus.o_layer),   exp_lay[k]);
                check("intt",    int'(bus.o_intt),    int'(mode));
                check("permute", int'(bus.o_permute), int'(exp_perm[k]));
            end else begin
                check("permute_idle", int'(bus.o_permute), 0);
            end
            if (exp_wr[k]) check("wr_addr", int'(bus.o_wr_addr), exp_wadr[k]);
            if (bus.o_rd_en) rd_cyc.push_back(k);
            if (bus.o_wr_en) wr_cyc.push_back(k);
            if (bus.o_done && obs_done < 0) obs_done = k;
            if (bus.o_permute && perm_first < 0) perm_first = k;
            bus.i_start = hold_start || (k == busy_pulse);
            bus.i_intt  = (k == busy_pulse) ? 1'b1 : mode;
            bus.i_stall = stl[k];
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check({tag, "_busy"},  int'(bus.o_busy),  0);
            check({tag, "_rd_en"}, int'(bus.o_rd_en), 0);
            check({tag, "_wr_en"}, int'(bus.o_wr_en), 0);
            check({tag, "_done"},  int'(bus.o_done),  0);
        end
    endtask

    function automatic int q_at(input int which, input int idx);
        if (which == 0) return (idx < rd_cyc.size()) ? rd_cyc[idx] : -1;
        return (idx < wr_cyc.size()) ? wr_cyc[idx] : -1;
    endfunction

    initial begin
        bus.i_start = 1'b0;
        bus.i_intt  = 1'b0;
        bus.i_stall = 1'b0;
        clear_stall();

        repeat (2) @(negedge i_clk);
        check("reset_outs", outs_packed(), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_outs", outs_packed(), 0);

        // NTT, no stall
        run_xform(1'b0, 1'b0, 0);
        check("ntt_done_cyc", obs_done, 57);
        check("ntt_rd_count", rd_cyc.size(), 32);
        check("ntt_wr_count", wr_cyc.size(), 32);
        check("ntt_rd_l1_first", q_at(0, 4), 8);
        check("ntt_wr_first", q_at(1, 0), 4);
        check("ntt_wr_l0_last", q_at(1, 3), 7);
        check("ntt_perm_first", perm_first, 50);

        // INTT, no stall
        run_xform(1'b1, 1'b0, 0);
        check("intt_done_cyc", obs_done, 57);
        check("intt_perm_seen", perm_first, -1);
        check("intt_rd_count", rd_cyc.size(), 32);

        // Two stalled slots right after beat 0
        clear_stall();
        stl[1] = 1'b1;
        stl[2] = 1'b1;
        run_xform(1'b0, 1'b0, 0);
        check("stall_beat1_rd", q_at(0, 1), 4);
        check("stall_beat1_wr", q_at(1, 1), 7);
        check("stall_rd_count", rd_cyc.size(), 32);
        check("stall_wr_count", wr_cyc.size(), 32);
        check("stall_done_cyc", obs_done, 59);

        // INTT start pulsed while busy is ignored
        clear_stall();
        run_xform(1'b0, 1'b0, 20);
        check("busy_start_done", obs_done, 57);
        check("busy_start_perm", perm_first, 50);
        idle_check("busy_start_after", 12);

        // Back-to-back with i_start held high
        run_xform(1'b0, 1'b1, 0);
        run_xform(1'b1, 1'b0, 0);
        check("b2b_first_rd", q_at(0, 0), 1);
        check("b2b_done_cyc", obs_done, 57);

        // Reset in the middle of layer 4
        clear_stall();
        bus.i_start = 1'b1;
        bus.i_intt  = 1'b0;
        bus.i_stall = 1'b0;
        for (int k = 1; k < 30; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            bus.i_start = 1'b0;
        end
        check("pre_rst_busy", int'(bus.o_busy), 1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1 check("rst_mid_outs", outs_packed(), 0);
        @(negedge i_clk);
        check("rst_mid_outs_c30", outs_packed(), 0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst_mid_outs_c31", outs_packed(), 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        idle_check("post_rst", 60);

        // Recovery, then randomized stall patterns and modes, chained
        run_xform(1'b0, 1'b0, 0);
        check("recover_done", obs_done, 57);
        for (int r = 0; r < 6; r++) begin
            bit m;
            bit h;
            m = 1'($urandom_range(1));
            h = 1'($urandom_range(1));
            rand_stall(($urandom_range(1) == 0) ? 3 : 5);
            run_xform(m, h, 0);
            check("rand_rd_count", rd_cyc.size(), NB * NL);
            check("rand_wr_count", wr_cyc.size(), NB * NL);
            check("rand_done_cyc", obs_done, exp_done);
        end
        idle_check("final", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
